// File: rtl/alu16_sequencer_if.sv
// Bundle of request/response handshake and 8-bit ALU port signals for alu16_sequencer.
// master = the sequencer side; slave = the decoder/register-file plus ALU side.
interface alu16_sequencer_if;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        flags_we;
  logic        flag_h;
  logic        flag_c;
  logic        flag_z_clr;
  logic        alu_en;
  logic [7:0]  alu_op1;
  logic [7:0]  alu_op2;
  logic        alu_cin;
  logic [7:0]  alu_res;
  logic        alu_cout;
  logic        alu_hout;

  modport master (
    input  flush, req_valid, req_op, req_a, req_b, rsp_ready,
           alu_res, alu_cout, alu_hout,
    output req_ready, rsp_valid, rsp_data, flags_we, flag_h, flag_c, flag_z_clr,
           alu_en, alu_op1, alu_op2, alu_cin
  );

  modport slave (
    output flush, req_valid, req_op, req_a, req_b, rsp_ready,
           alu_res, alu_cout, alu_hout,
    input  req_ready, rsp_valid, rsp_data, flags_we, flag_h, flag_c, flag_z_clr,
           alu_en, alu_op1, alu_op2, alu_cin
  );
endinterface

// File: rtl/alu16_sequencer.sv
// 16-bit ADD HL / ADD SP,e / INC16 / DEC16 built from two chained passes of an external
// combinational 8-bit ALU (low byte, then high byte with carry forwarded).
module alu16_sequencer (
  input  logic                CLK,
  input  logic                nRESET,
  alu16_sequencer_if.master   bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOW  = 2'd1;
  localparam logic [1:0] HIGH = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [1:0] OP_ADD_HL   = 2'b00;
  localparam logic [1:0] OP_ADD_SP_E = 2'b01;
  localparam logic [1:0] OP_INC16    = 2'b10;

  logic [1:0]  state_reg;
  logic [1:0]  op_reg;
  logic [15:0] a_reg;
  logic [15:0] b_reg;
  logic [7:0]  res_lo_reg;
  logic [7:0]  res_hi_reg;
  logic        c_lo_reg;
  logic        h_lo_reg;
  logic        c_hi_reg;
  logic        h_hi_reg;

  logic        req_ready;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        flags_we;
  logic        flag_h;
  logic        flag_c;
  logic        flag_z_clr;
  logic        alu_en;
  logic [7:0]  alu_op1;
  logic [7:0]  alu_op2;
  logic        alu_cin;

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_reg  <= IDLE;
      op_reg     <= 2'b00;
      a_reg      <= 16'h0000;
      b_reg      <= 16'h0000;
      res_lo_reg <= 8'h00;
      res_hi_reg <= 8'h00;
      c_lo_reg   <= 1'b0;
      h_lo_reg   <= 1'b0;
      c_hi_reg   <= 1'b0;
      h_hi_reg   <= 1'b0;
    end else if (bus.flush) begin
      // Abort wins over everything, including a request presented in the same cycle.
      state_reg <= IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.req_valid) begin
            op_reg    <= bus.req_op;
            a_reg     <= bus.req_a;
            b_reg     <= bus.req_b;
            state_reg <= LOW;
          end
        end
        LOW: begin
          res_lo_reg <= bus.alu_res;
          c_lo_reg   <= bus.alu_cout;
          h_lo_reg   <= bus.alu_hout;
          state_reg  <= HIGH;
        end
        HIGH: begin
          res_hi_reg <= bus.alu_res;
          c_hi_reg   <= bus.alu_cout;
          h_hi_reg   <= bus.alu_hout;
          state_reg  <= DONE;
        end
        default: begin
          if (bus.rsp_ready) begin
            state_reg <= IDLE;
          end
        end
      endcase
    end
  end

  always_comb begin
    req_ready  = (state_reg == IDLE);
    alu_en     = 1'b0;
    alu_op1    = 8'h00;
    alu_op2    = 8'h00;
    alu_cin    = 1'b0;
    rsp_valid  = 1'b0;
    rsp_data   = 16'h0000;
    flags_we   = 1'b0;
    flag_h     = 1'b0;
    flag_c     = 1'b0;
    flag_z_clr = 1'b0;
    case (state_reg)
      LOW: begin
        alu_en  = 1'b1;
        alu_op1 = a_reg[7:0];
        case (op_reg)
          OP_ADD_HL, OP_ADD_SP_E: alu_op2 = b_reg[7:0];
          OP_INC16:               alu_op2 = 8'h01;
          default:                alu_op2 = 8'hFF;
        endcase
      end
      HIGH: begin
        alu_en  = 1'b1;
        alu_op1 = a_reg[15:8];
        alu_cin = c_lo_reg;
        // DEC16 is a + 0xFFFF, and ADD SP,e sign-extends e into the high byte.
        case (op_reg)
          OP_ADD_HL:   alu_op2 = b_reg[15:8];
          OP_ADD_SP_E: alu_op2 = {8{b_reg[7]}};
          OP_INC16:    alu_op2 = 8'h00;
          default:     alu_op2 = 8'hFF;
        endcase
      end
      DONE: begin
        rsp_valid = 1'b1;
        rsp_data  = {res_hi_reg, res_lo_reg};
        case (op_reg)
          OP_ADD_HL: begin
            flags_we = 1'b1;
            flag_h   = h_hi_reg;
            flag_c   = c_hi_reg;
          end
          OP_ADD_SP_E: begin
            flags_we   = 1'b1;
            flag_h     = h_lo_reg;
            flag_c     = c_lo_reg;
            flag_z_clr = 1'b1;
          end
          default: begin
            flags_we = 1'b0;
          end
        endcase
      end
      default: begin
        req_ready = 1'b1;
      end
    endcase
  end

  assign bus.req_ready  = req_ready;
  assign bus.rsp_valid  = rsp_valid;
  assign bus.rsp_data   = rsp_data;
  assign bus.flags_we   = flags_we;
  assign bus.flag_h     = flag_h;
  assign bus.flag_c     = flag_c;
  assign bus.flag_z_clr = flag_z_clr;
  assign bus.alu_en     = alu_en;
  assign bus.alu_op1    = alu_op1;
  assign bus.alu_op2    = alu_op2;
  assign bus.alu_cin    = alu_cin;

endmodule

// File: tb/tb_alu16_sequencer.sv
// Directed bench for alu16_sequencer with a combinational 8-bit ALU model attached.
module tb_alu16_sequencer;

  logic clk;
  logic nreset;
  int   passed;
  int   total;

  alu16_sequencer_if bus ();

  alu16_sequencer dut (
    .CLK    (clk),
    .nRESET (nreset),
    .bus    (bus)
  );

  logic [8:0] alu_sum;
  logic [4:0] alu_nib;
  assign alu_sum      = {1'b0, bus.alu_op1} + {1'b0, bus.alu_op2} + {8'h00, bus.alu_cin};
  assign alu_nib      = {1'b0, bus.alu_op1[3:0]} + {1'b0, bus.alu_op2[3:0]} + {4'h0, bus.alu_cin};
  assign bus.alu_res  = alu_sum[7:0];
  assign bus.alu_cout = alu_sum[8];
  assign bus.alu_hout = alu_nib[4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic run_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [7:0] exp_op2_lo, input logic [7:0] exp_op2_hi,
                        input logic exp_cin_hi, input logic [15:0] exp_data,
                        input logic [3:0] exp_flags, input string name);
    @(negedge clk);
    total++;
    if (bus.req_ready !== 1'b1) $display("FAIL %s idle_ready got=%b want=1", name, bus.req_ready);
    else passed++;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.rsp_ready = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_a     = 16'hDEAD;
    bus.req_b     = 16'hBEEF;
    total++;
    if ({bus.alu_en, bus.alu_op1, bus.alu_op2, bus.alu_cin, bus.req_ready, bus.rsp_valid}
        !== {1'b1, a[7:0], exp_op2_lo, 1'b0, 1'b0, 1'b0})
      $display("FAIL %s low_pass got en=%b op1=%h op2=%h cin=%b rdy=%b vld=%b want en=1 op1=%h op2=%h cin=0 rdy=0 vld=0",
               name, bus.alu_en, bus.alu_op1, bus.alu_op2, bus.alu_cin, bus.req_ready, bus.rsp_valid,
               a[7:0], exp_op2_lo);
    else passed++;
    @(posedge clk); #1;
    total++;
    if ({bus.alu_en, bus.alu_op1, bus.alu_op2, bus.alu_cin, bus.rsp_valid}
        !== {1'b1, a[15:8], exp_op2_hi, exp_cin_hi, 1'b0})
      $display("FAIL %s high_pass got en=%b op1=%h op2=%h cin=%b vld=%b want en=1 op1=%h op2=%h cin=%b vld=0",
               name, bus.alu_en, bus.alu_op1, bus.alu_op2, bus.alu_cin, bus.rsp_valid,
               a[15:8], exp_op2_hi, exp_cin_hi);
    else passed++;
    @(posedge clk); #1;
    total++;
    if ({bus.rsp_valid, bus.rsp_data, bus.flags_we, bus.flag_h, bus.flag_c, bus.flag_z_clr,
         bus.req_ready, bus.alu_en} !== {1'b1, exp_data, exp_flags, 1'b0, 1'b0})
      $display("FAIL %s response got vld=%b data=%h we/h/c/z=%b rdy=%b en=%b want vld=1 data=%h we/h/c/z=%b rdy=0 en=0",
               name, bus.rsp_valid, bus.rsp_data,
               {bus.flags_we, bus.flag_h, bus.flag_c, bus.flag_z_clr}, bus.req_ready, bus.alu_en,
               exp_data, exp_flags);
    else passed++;
    $display("op %s: op=%b a=%h b=%h -> data=%h we/h/c/z=%b", name, op, a, b, bus.rsp_data,
             {bus.flags_we, bus.flag_h, bus.flag_c, bus.flag_z_clr});
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    total++;
    if ({bus.rsp_valid, bus.rsp_data, bus.flags_we, bus.req_ready} !== {1'b0, 16'h0000, 1'b0, 1'b1})
      $display("FAIL %s after_accept got vld=%b data=%h we=%b rdy=%b want vld=0 data=0000 we=0 rdy=1",
               name, bus.rsp_valid, bus.rsp_data, bus.flags_we, bus.req_ready);
    else passed++;
  endtask

  task automatic test_reset();
    nreset        = 1'b0;
    bus.flush     = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b00;
    bus.req_a     = 16'h1234;
    bus.req_b     = 16'h4321;
    bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.flags_we, bus.flag_h, bus.flag_c,
         bus.flag_z_clr, bus.alu_en, bus.alu_op1, bus.alu_op2, bus.alu_cin}
        !== {1'b1, 1'b0, 16'h0000, 4'b0000, 1'b0, 8'h00, 8'h00, 1'b0})
      $display("FAIL reset_state got rdy=%b vld=%b data=%h flags=%b en=%b op1=%h op2=%h cin=%b",
               bus.req_ready, bus.rsp_valid, bus.rsp_data,
               {bus.flags_we, bus.flag_h, bus.flag_c, bus.flag_z_clr},
               bus.alu_en, bus.alu_op1, bus.alu_op2, bus.alu_cin);
    else passed++;
    $display("reset: rdy=%b vld=%b en=%b", bus.req_ready, bus.rsp_valid, bus.alu_en);
    bus.req_valid = 1'b0;
    @(negedge clk);
    nreset = 1'b1;
  endtask

  task automatic test_add_hl();
    run_op(2'b00, 16'h0FFF, 16'h0001, 8'h01, 8'h00, 1'b1, 16'h1000, 4'b1100, "add_hl_half");
    run_op(2'b00, 16'hFFFF, 16'h0001, 8'h01, 8'h00, 1'b1, 16'h0000, 4'b1110, "add_hl_wrap");
    run_op(2'b00, 16'h1234, 16'h1111, 8'h11, 8'h11, 1'b0, 16'h2345, 4'b1000, "add_hl_plain");
  endtask

  task automatic test_add_sp_e();
    run_op(2'b01, 16'h0005, 16'h00FE, 8'hFE, 8'hFF, 1'b1, 16'h0003, 4'b1111, "add_sp_neg");
    run_op(2'b01, 16'hFFF8, 16'h0008, 8'h08, 8'h00, 1'b1, 16'h0000, 4'b1111, "add_sp_wrap");
    run_op(2'b01, 16'h1000, 16'hAB05, 8'h05, 8'h00, 1'b0, 16'h1005, 4'b1001, "add_sp_pos");
  endtask

  task automatic test_inc_dec();
    run_op(2'b11, 16'h0000, 16'h1234, 8'hFF, 8'hFF, 1'b0, 16'hFFFF, 4'b0000, "dec_zero");
    run_op(2'b10, 16'hFFFF, 16'h5555, 8'h01, 8'h00, 1'b1, 16'h0000, 4'b0000, "inc_wrap");
    run_op(2'b11, 16'h0100, 16'h0000, 8'hFF, 8'hFF, 1'b0, 16'h00FF, 4'b0000, "dec_borrow");
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b00;
    bus.req_a     = 16'h00F0;
    bus.req_b     = 16'h0010;
    @(posedge clk); #1;
    bus.req_op = 2'b10;
    bus.req_a  = 16'h7FFF;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({bus.rsp_valid, bus.rsp_data, bus.flags_we, bus.flag_h, bus.flag_c, bus.flag_z_clr,
           bus.req_ready} !== {1'b1, 16'h0100, 4'b1000, 1'b0})
        $display("FAIL stall_hold[%0d] got vld=%b data=%h flags=%b rdy=%b want vld=1 data=0100 flags=1000 rdy=0",
                 i, bus.rsp_valid, bus.rsp_data,
                 {bus.flags_we, bus.flag_h, bus.flag_c, bus.flag_z_clr}, bus.req_ready);
      else passed++;
      @(posedge clk); #1;
    end
    $display("stall: held data=%h for 5 cycles", bus.rsp_data);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    total++;
    if ({bus.req_ready, bus.rsp_valid, bus.alu_en} !== 3'b100)
      $display("FAIL stall_release got rdy=%b vld=%b en=%b want rdy=1 vld=0 en=0",
               bus.req_ready, bus.rsp_valid, bus.alu_en);
    else passed++;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    total++;
    if ({bus.alu_en, bus.alu_op1, bus.alu_op2, bus.req_ready} !== {1'b1, 8'hFF, 8'h01, 1'b0})
      $display("FAIL stall_next_accept got en=%b op1=%h op2=%h rdy=%b want en=1 op1=ff op2=01 rdy=0",
               bus.alu_en, bus.alu_op1, bus.alu_op2, bus.req_ready);
    else passed++;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({bus.rsp_valid, bus.rsp_data, bus.flags_we} !== {1'b1, 16'h8000, 1'b0})
      $display("FAIL stall_next_result got vld=%b data=%h we=%b want vld=1 data=8000 we=0",
               bus.rsp_valid, bus.rsp_data, bus.flags_we);
    else passed++;
    $display("op next_inc: a=7fff -> data=%h", bus.rsp_data);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_flush();
    int seen_valid;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b00;
    bus.req_a     = 16'h1111;
    bus.req_b     = 16'h2222;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.flush     = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({bus.req_ready, bus.alu_en, bus.rsp_valid} !== 3'b100)
      $display("FAIL flush_low got rdy=%b en=%b vld=%b want rdy=1 en=0 vld=0",
               bus.req_ready, bus.alu_en, bus.rsp_valid);
    else passed++;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({bus.req_ready, bus.alu_en} !== 2'b10)
      $display("FAIL flush_blocks_req got rdy=%b en=%b want rdy=1 en=0", bus.req_ready, bus.alu_en);
    else passed++;
    bus.req_valid = 1'b0;
    bus.flush     = 1'b0;
    seen_valid    = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid === 1'b1) seen_valid++;
    end
    total++;
    if (seen_valid !== 0) $display("FAIL flush_no_rsp got valid_cycles=%0d want 0", seen_valid);
    else passed++;
    $display("flush: in LOW, valid_cycles=%0d", seen_valid);

    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_a     = 16'h0001;
    bus.req_b     = 16'h0001;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus.flush     = 1'b1;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.flush     = 1'b0;
    bus.rsp_ready = 1'b0;
    total++;
    if ({bus.req_ready, bus.rsp_valid} !== 2'b10)
      $display("FAIL flush_done got rdy=%b vld=%b want rdy=1 vld=0", bus.req_ready, bus.rsp_valid);
    else passed++;
    $display("flush: in DONE with rsp_ready, rdy=%b", bus.req_ready);
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b00;
    bus.req_a     = 16'hABCD;
    bus.req_b     = 16'h1111;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({bus.alu_en, bus.alu_op1} !== {1'b1, 8'hAB})
      $display("FAIL pre_reset_high got en=%b op1=%h want en=1 op1=ab", bus.alu_en, bus.alu_op1);
    else passed++;
    #1;
    nreset = 1'b0;
    #1;
    total++;
    if ({bus.req_ready, bus.rsp_valid, bus.alu_en, bus.alu_op1, bus.alu_op2, bus.alu_cin}
        !== {1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0})
      $display("FAIL async_reset got rdy=%b vld=%b en=%b op1=%h op2=%h cin=%b want rdy=1 rest 0",
               bus.req_ready, bus.rsp_valid, bus.alu_en, bus.alu_op1, bus.alu_op2, bus.alu_cin);
    else passed++;
    $display("reset mid-op: rdy=%b en=%b", bus.req_ready, bus.alu_en);
    @(negedge clk);
    nreset = 1'b1;
    run_op(2'b00, 16'h0FFF, 16'h0001, 8'h01, 8'h00, 1'b1, 16'h1000, 4'b1100, "post_reset");
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_add_hl();
    test_add_sp_e();
    test_inc_dec();
    test_back_to_back();
    test_flush();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
